// File: rtl/fsab_master_port.sv
// FSAB master port: turns client read/write commands into credit-limited FSAB
// request packets and forwards matching read responses back to the client.
`timescale 1ns/1ps

module fsab_master_port #(
  parameter int unsigned DID          = 0,
  parameter int unsigned SUBDID       = 0,
  parameter int unsigned INIT_CREDITS = 4,
  parameter int unsigned LEN_MAX      = 8,
  localparam int FSAB_REQ_HI  = 0,
  localparam int FSAB_DID_HI  = 3,
  localparam int FSAB_ADDR_HI = 30,
  localparam int FSAB_LEN_HI  = 3,
  localparam int FSAB_DATA_HI = 63,
  localparam int FSAB_MASK_HI = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [FSAB_REQ_HI:0]  cmd_mode,
  input  logic [FSAB_ADDR_HI:0] cmd_addr,
  input  logic [FSAB_LEN_HI:0]  cmd_len,
  input  logic                  wdat_valid,
  output logic                  wdat_ready,
  input  logic [FSAB_DATA_HI:0] wdat_data,
  input  logic [FSAB_MASK_HI:0] wdat_mask,
  output logic                  fsab_valid,
  output logic [FSAB_REQ_HI:0]  fsab_mode,
  output logic [FSAB_DID_HI:0]  fsab_did,
  output logic [FSAB_DID_HI:0]  fsab_subdid,
  output logic [FSAB_ADDR_HI:0] fsab_addr,
  output logic [FSAB_LEN_HI:0]  fsab_len,
  output logic [FSAB_DATA_HI:0] fsab_data,
  output logic [FSAB_MASK_HI:0] fsab_mask,
  input  logic                  fsab_credit,
  input  logic                  fsabi_valid,
  input  logic [FSAB_DID_HI:0]  fsabi_did,
  input  logic [FSAB_DID_HI:0]  fsabi_subdid,
  input  logic [FSAB_DATA_HI:0] fsabi_data,
  output logic                  rsp_valid,
  output logic [FSAB_DATA_HI:0] rsp_data,
  output logic                  credit_err
);

  localparam int CW = $clog2(INIT_CREDITS + 1);
  localparam int LW = FSAB_LEN_HI + 1;
  localparam int DW = FSAB_DID_HI + 1;
  localparam int IW = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
  localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = (FSAB_REQ_HI + 1)'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StWaitCredit, StSend, StRdWait} state_e;

  state_e                state_q;
  logic [FSAB_REQ_HI:0]  mode_q;
  logic [FSAB_ADDR_HI:0] addr_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         cnt_q;
  logic [CW-1:0]         credit_q;

  logic [FSAB_DATA_HI:0] wbuf_data [LEN_MAX];
  logic [FSAB_MASK_HI:0] wbuf_mask [LEN_MAX];

  logic [LW-1:0] cmd_len_eff;
  logic [LW-1:0] len_last;
  logic [LW-1:0] cnt_inc;
  logic          is_write;
  logic          rsp_match;
  logic          head;

  // Zero-length commands become single beats; oversize ones are clipped to the buffer.
  always_comb begin
    cmd_len_eff = cmd_len;
    if (cmd_len == '0) begin
      cmd_len_eff = LW'(1);
    end else if (cmd_len > LW'(LEN_MAX)) begin
      cmd_len_eff = LW'(LEN_MAX);
    end
  end

  assign len_last   = len_q - LW'(1);
  assign cnt_inc    = cnt_q + LW'(1);
  assign is_write   = (mode_q == FSAB_WRITE);
  assign rsp_match  = fsabi_valid && (fsabi_did == DW'(DID)) && (fsabi_subdid == DW'(SUBDID));
  assign head       = fsab_valid && (cnt_q == '0);
  assign cmd_ready  = (state_q == StIdle);
  assign wdat_ready = (state_q == StLoad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q   <= CW'(INIT_CREDITS);
      credit_err <= 1'b0;
    end else if (head && !fsab_credit) begin
      credit_q <= credit_q - CW'(1);
    end else if (fsab_credit && !head) begin
      // A return with every credit already home means the fabric lost count.
      if (credit_q == CW'(INIT_CREDITS)) begin
        credit_err <= 1'b1;
      end else begin
        credit_q <= credit_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == StLoad) && wdat_valid) begin
      wbuf_data[cnt_q[IW-1:0]] <= wdat_data;
      wbuf_mask[cnt_q[IW-1:0]] <= wdat_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      fsab_valid  <= 1'b0;
      fsab_mode   <= '0;
      fsab_did    <= '0;
      fsab_subdid <= '0;
      fsab_addr   <= '0;
      fsab_len    <= '0;
      fsab_data   <= '0;
      fsab_mask   <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            mode_q  <= cmd_mode;
            addr_q  <= cmd_addr;
            len_q   <= cmd_len_eff;
            cnt_q   <= '0;
            state_q <= (cmd_mode == FSAB_WRITE) ? StLoad : StWaitCredit;
          end
        end
        StLoad: begin
          if (wdat_valid) begin
            if (cnt_q == len_last) begin
              cnt_q   <= '0;
              state_q <= StWaitCredit;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        StWaitCredit: begin
          if (credit_q != '0) begin
            state_q     <= StSend;
            cnt_q       <= '0;
            fsab_valid  <= 1'b1;
            fsab_mode   <= mode_q;
            fsab_did    <= DW'(DID);
            fsab_subdid <= DW'(SUBDID);
            fsab_addr   <= addr_q;
            fsab_len    <= len_q;
            fsab_data   <= is_write ? wbuf_data[IW'(0)] : '0;
            fsab_mask   <= is_write ? wbuf_mask[IW'(0)] : '0;
          end
        end
        StSend: begin
          if (!is_write || (cnt_q == len_last)) begin
            state_q     <= is_write ? StIdle : StRdWait;
            cnt_q       <= '0;
            fsab_valid  <= 1'b0;
            fsab_mode   <= '0;
            fsab_did    <= '0;
            fsab_subdid <= '0;
            fsab_addr   <= '0;
            fsab_len    <= '0;
            fsab_data   <= '0;
            fsab_mask   <= '0;
          end else begin
            cnt_q     <= cnt_inc;
            fsab_data <= wbuf_data[cnt_inc[IW-1:0]];
            fsab_mask <= wbuf_mask[cnt_inc[IW-1:0]];
          end
        end
        StRdWait: begin
          if (rsp_match) begin
            rsp_valid <= 1'b1;
            rsp_data  <= fsabi_data;
            if (cnt_q == len_last) begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fsab_master_port.sv
// Randomized bench for fsab_master_port: transaction-level model of the FSAB
// beat stream, credit count and read responses, checked every cycle.
`timescale 1ns/1ps

module tb_fsab_master_port;

  localparam int unsigned INIT = 4;
  localparam int unsigned BOUND = 400;
  localparam logic [3:0] MY_DID = 4'd5;
  localparam logic [3:0] MY_SUB = 4'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [0:0]  cmd_mode;
  logic [30:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wdat_valid, wdat_ready;
  logic [63:0] wdat_data;
  logic [7:0]  wdat_mask;
  logic        fsab_valid;
  logic [0:0]  fsab_mode;
  logic [3:0]  fsab_did, fsab_subdid;
  logic [30:0] fsab_addr;
  logic [3:0]  fsab_len;
  logic [63:0] fsab_data;
  logic [7:0]  fsab_mask;
  logic        fsab_credit;
  logic        fsabi_valid;
  logic [3:0]  fsabi_did, fsabi_subdid;
  logic [63:0] fsabi_data;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        credit_err;

  fsab_master_port #(
    .DID         (5),
    .SUBDID      (2),
    .INIT_CREDITS(INIT),
    .LEN_MAX     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdat_valid  (wdat_valid),
    .wdat_ready  (wdat_ready),
    .wdat_data   (wdat_data),
    .wdat_mask   (wdat_mask),
    .fsab_valid  (fsab_valid),
    .fsab_mode   (fsab_mode),
    .fsab_did    (fsab_did),
    .fsab_subdid (fsab_subdid),
    .fsab_addr   (fsab_addr),
    .fsab_len    (fsab_len),
    .fsab_data   (fsab_data),
    .fsab_mask   (fsab_mask),
    .fsab_credit (fsab_credit),
    .fsabi_valid (fsabi_valid),
    .fsabi_did   (fsabi_did),
    .fsabi_subdid(fsabi_subdid),
    .fsabi_data  (fsabi_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .credit_err  (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:0]  mode;
    logic [3:0]  did;
    logic [3:0]  sub;
    logic [30:0] addr;
    logic [3:0]  len;
    logic [63:0] data;
    logic [7:0]  mask;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    int unsigned due;
  } rsp_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  beat_t       exp_beats[$];
  rsp_t        exp_rsp[$];
  int          mcred = INIT;
  bit          merr = 1'b0;
  int          rem = 0;
  int          beat_count = 0;
  int          rsp_count = 0;
  bit          done = 1'b0;
  logic [63:0] wd [8];
  logic [7:0]  wm [8];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of the DUT against the transaction model.
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    bit    hd;
    got = {fsab_mode, fsab_did, fsab_subdid, fsab_addr, fsab_len, fsab_data, fsab_mask};
    hd  = 1'b0;
    if (rst) begin
      mcred = INIT;
      merr  = 1'b0;
      rem   = 0;
      exp_beats.delete();
      exp_rsp.delete();
      check("rst_fsab_valid", fsab_valid, 1'b0);
    end else begin
      check("credits", dut.credit_q, mcred);
      check("credit_err", credit_err, merr);
      if (fsab_valid) begin
        check("beat_expected", exp_beats.size() != 0, 1'b1);
        if (exp_beats.size() != 0) begin
          e = exp_beats.pop_front();
          check("fsab_beat", got, e);
          beat_count++;
          if (rem == 0) begin
            hd = 1'b1;
            check("credit_avail_at_head", mcred > 0, 1'b1);
            rem = (e.mode == 1'b1) ? int'(e.len) - 1 : 0;
          end else begin
            rem--;
          end
        end
      end else begin
        check("idle_fields_zero", got, '0);
        check("no_write_gap", rem == 0, 1'b1);
        rem = 0;
      end
      if (exp_rsp.size() != 0 && exp_rsp[0].due == cyc) begin
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_data", rsp_data, exp_rsp[0].data);
        void'(exp_rsp.pop_front());
        rsp_count++;
      end else begin
        check("rsp_idle", rsp_valid, 1'b0);
      end
      if (hd && !fsab_credit) begin
        mcred--;
      end else if (fsab_credit && !hd) begin
        if (mcred == INIT) merr = 1'b1;
        else mcred++;
      end
    end
  end

  // Read responder: every matching beat is preceded by a foreign-owner beat.
  initial begin
    int len;
    fsabi_valid  = 1'b0;
    fsabi_did    = '0;
    fsabi_subdid = '0;
    fsabi_data   = '0;
    forever begin
      @(negedge clk);
      if (!rst && fsab_valid && fsab_mode == 1'b0) begin
        len = int'(fsab_len);
        for (int k = 0; k < len; k++) begin
          tick();
          fsabi_valid = 1'b1;
          fsabi_data  = {$urandom, $urandom};
          if ($urandom_range(0, 1) == 1) begin
            fsabi_did    = MY_DID ^ 4'h1;
            fsabi_subdid = MY_SUB;
          end else begin
            fsabi_did    = MY_DID;
            fsabi_subdid = MY_SUB ^ 4'h1;
          end
          tick();
          if ($urandom_range(0, 2) == 0) begin
            fsabi_valid = 1'b0;
            tick();
          end
          fsabi_valid  = 1'b1;
          fsabi_did    = MY_DID;
          fsabi_subdid = MY_SUB;
          fsabi_data   = {$urandom, $urandom};
          exp_rsp.push_back('{fsabi_data, cyc + 1});
        end
        tick();
        fsabi_valid  = 1'b0;
        fsabi_did    = '0;
        fsabi_subdid = '0;
        fsabi_data   = '0;
      end
    end
  end

  task automatic send_cmd(input logic m, input logic [30:0] a, input logic [3:0] l);
    int n;
    int leff;
    n    = 0;
    leff = (l == 0) ? 1 : int'(l);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_addr  = a;
    cmd_len   = l;
    while (!cmd_ready && n < BOUND) begin
      tick();
      n++;
    end
    check("cmd_accept_in_time", cmd_ready, 1'b1);
    if (m == 1'b1) begin
      for (int i = 0; i < leff; i++)
        exp_beats.push_back({1'b1, MY_DID, MY_SUB, a, 4'(leff), wd[i], wm[i]});
    end else begin
      exp_beats.push_back({1'b0, MY_DID, MY_SUB, a, 4'(leff), 64'h0, 8'h0});
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [30:0] a, input logic [3:0] l, input bit stall);
    int leff;
    int n;
    leff = (l == 0) ? 1 : int'(l);
    for (int i = 0; i < 8; i++) begin
      wd[i] = {$urandom, $urandom};
      wm[i] = 8'($urandom);
    end
    send_cmd(1'b1, a, l);
    for (int i = 0; i < leff; i++) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        wdat_valid = 1'b0;
        wdat_data  = {$urandom, $urandom};
        tick();
      end
      wdat_valid = 1'b1;
      wdat_data  = wd[i];
      wdat_mask  = wm[i];
      n = 0;
      while (!wdat_ready && n < BOUND) begin
        tick();
        n++;
      end
      check("wdat_accept_in_time", wdat_ready, 1'b1);
      tick();
    end
    wdat_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_beats.size() == 0 && rem == 0 && exp_rsp.size() == 0 && cmd_ready) && n < BOUND) begin
      tick();
      n++;
    end
    check("reach_idle_in_time", n < BOUND, 1'b1);
  endtask

  task automatic wait_head();
    int n;
    n = 0;
    while (!fsab_valid && n < 50) begin
      tick();
      n++;
    end
    check("head_beat_seen", fsab_valid, 1'b1);
  endtask

  task automatic pulse_credit();
    fsab_credit = 1'b1;
    tick();
    fsab_credit = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int b0;
    int r0;
    bit found;
    int n;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_mode    = '0;
    cmd_addr    = '0;
    cmd_len     = '0;
    wdat_valid  = 1'b0;
    wdat_data   = '0;
    wdat_mask   = '0;
    fsab_credit = 1'b0;
    tick();
    apply_reset();

    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_wdat_ready", wdat_ready, 1'b0);
    check("reset_fsab_valid", fsab_valid, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_credit_err", credit_err, 1'b0);
    check("reset_credits", dut.credit_q, 3'd4);

    // Len-4 write at 0x100 with one data beat per cycle.
    b0 = beat_count;
    do_write(31'h100, 4'd4, 1'b0);
    wait_idle();
    check("w4_beats", beat_count - b0, 4);
    check("w4_credits", dut.credit_q, 3'd3);

    // Credit return coincident with a head beat at two credits.
    do_write(31'h200, 4'd1, 1'b0);
    wait_idle();
    check("credits_before_coincident", dut.credit_q, 3'd2);
    do_write(31'h204, 4'd1, 1'b0);
    wait_head();
    pulse_credit();
    check("coincident_credits", dut.credit_q, 3'd2);
    wait_idle();

    // Overflow at full credits while idle is sticky until reset.
    pulse_credit();
    pulse_credit();
    check("credits_full", dut.credit_q, 3'd4);
    check("no_err_yet", credit_err, 1'b0);
    pulse_credit();
    tick();
    check("overflow_credits", dut.credit_q, 3'd4);
    check("overflow_err", credit_err, 1'b1);
    repeat (5) tick();
    check("err_sticky", credit_err, 1'b1);
    apply_reset();
    check("err_cleared", credit_err, 1'b0);

    // Five single-beat writes with no credit return.
    b0 = beat_count;
    for (int i = 0; i < 5; i++) do_write(31'(32'h300 + 4 * i), 4'd1, 1'b0);
    repeat (8) tick();
    check("five_w_issued", beat_count - b0, 4);
    check("five_w_credits", dut.credit_q, 3'd0);
    check("five_w_held", cmd_ready, 1'b0);
    pulse_credit();
    found = fsab_valid;
    if (!found) begin
      tick();
      found = fsab_valid;
    end
    check("credit_to_head_latency", found, 1'b1);
    wait_idle();
    repeat (4) pulse_credit();
    tick();
    check("five_w_refilled", dut.credit_q, 3'd4);

    // Reads with interleaved foreign responses; len 0 acts as 1.
    r0 = rsp_count;
    send_cmd(1'b0, 31'h480, 4'd2);
    wait_idle();
    check("rd2_rsp_beats", rsp_count - r0, 2);
    check("rd2_back_idle", cmd_ready, 1'b1);
    r0 = rsp_count;
    send_cmd(1'b0, 31'h4c0, 4'd0);
    wait_idle();
    check("rd0_rsp_beats", rsp_count - r0, 1);
    pulse_credit();
    pulse_credit();

    // Reset on the second beat of a len-8 write.
    do_write(31'h500, 4'd8, 1'b0);
    wait_head();
    tick();
    rst = 1'b1;
    #1;
    check("midpkt_valid_drop", fsab_valid, 1'b0);
    check("midpkt_fields_zero",
          {fsab_mode, fsab_did, fsab_subdid, fsab_addr, fsab_len, fsab_data, fsab_mask}, '0);
    check("midpkt_credits", dut.credit_q, 3'd4);
    tick();
    rst = 1'b0;
    tick();
    b0 = beat_count;
    do_write(31'h600, 4'd2, 1'b0);
    wait_idle();
    check("post_rst_write_beats", beat_count - b0, 2);

    // Random mix with background credit returns.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 1) == 1)
            do_write(31'($urandom), 4'($urandom_range(0, 8)), 1'b1);
          else
            send_cmd(1'b0, 31'($urandom), 4'($urandom_range(0, 8)));
        end
        wait_idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          fsab_credit = (mcred < INIT) && ($urandom_range(0, 2) == 0);
        end
        fsab_credit = 1'b0;
      end
    join
    n = 0;
    while (mcred < INIT && n < 20) begin
      pulse_credit();
      n++;
    end
    tick();
    check("final_credits", dut.credit_q, 3'd4);
    check("final_no_err", credit_err, 1'b0);
    check("beats_drained", exp_beats.size(), 0);
    check("rsp_drained", exp_rsp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
